hazard_forward_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It is the consumer of the ID/EX pipeline register's outputs and the controller of that register's stall/bubble inputs. It keeps shadow copies of destination-register info for the MEM and WB stages and drives the EX operand forwarding selects. It also generates load-use stalls, branch flushes and memory-busy freezes for the PC, IF/ID and ID/EX registers.

---
 rtl/riscv_hazard_pkg.sv | 6 +
 rtl/fwd_compare.sv | 15 +
 rtl/hazard_forward_unit.sv | 80 ++++++++
 tb/tb_hazard_forward_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_hazard_pkg.sv
// riscv_hazard_pkg: shared types and constants for the hazard/forwarding unit
package riscv_hazard_pkg;
  typedef enum logic [1:0] {FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {RUN = 2'b00, LOAD_STALL = 2'b01, FLUSH = 2'b10, FREEZE = 2'b11} haz_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/fwd_compare.sv
// fwd_compare: selects the youngest in-flight producer of one EX source register
module fwd_compare
  import riscv_hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] memRd,
  input  logic       memWe,
  input  logic [4:0] wbRd,
  input  logic       wbWe,
  output fwd_sel_t   sel
);
  always_comb
    sel = (memWe && memRd != REG_ZERO && memRd == rs) ? FWD_MEM :
          (wbWe && wbRd != REG_ZERO && wbRd == rs) ? FWD_WB : FWD_NONE;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: stall/flush/freeze control and EX forwarding; HAZARD_PERF_CNT_EN adds cycle counters
module hazard_forward_unit
  import riscv_hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       usesRs1_ID,
  input  logic       usesRs2_ID,
  input  logic [4:0] rd_IDOut,
  input  logic [4:0] rs1_IDOut,
  input  logic [4:0] rs2_IDOut,
  input  logic       regWrite_IDOut,
  input  logic       memRead_IDOut,
  input  logic       branchTaken_EX,
  input  logic       memBusy_MEM,
  output logic       stallPC,
  output logic       stallIFID,
  output logic       bubbleIDEX,
  output logic       flushIFID,
  output logic       freeze,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB,
  output logic [1:0] hazState
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount,
  output logic [31:0] freezeCount
`endif
);
  logic [4:0] mem_rd, wb_rd;
  logic       mem_we, wb_we, load_use;
  haz_state_t act, haz_q;
  fwd_sel_t   fwd_a, fwd_b;
  fwd_compare u_fwd_a (.rs(rs1_IDOut), .memRd(mem_rd), .memWe(mem_we), .wbRd(wb_rd), .wbWe(wb_we), .sel(fwd_a));
  fwd_compare u_fwd_b (.rs(rs2_IDOut), .memRd(mem_rd), .memWe(mem_we), .wbRd(wb_rd), .wbWe(wb_we), .sel(fwd_b));
  always_comb begin
    load_use = memRead_IDOut && rd_IDOut != REG_ZERO &&
               ((usesRs1_ID && rs1_ID == rd_IDOut) || (usesRs2_ID && rs2_ID == rd_IDOut));
    act = memBusy_MEM ? FREEZE : branchTaken_EX ? FLUSH : load_use ? LOAD_STALL : RUN;
  end
  assign freeze     = act == FREEZE;
  assign flushIFID  = act == FLUSH;
  assign stallPC    = act == FREEZE || act == LOAD_STALL;
  assign stallIFID  = stallPC;
  assign bubbleIDEX = act == FLUSH || act == LOAD_STALL;
  assign forwardA   = fwd_a;
  assign forwardB   = fwd_b;
  assign hazState   = haz_q;
  always_ff @(posedge clk)
    if (rst) begin
      mem_rd <= REG_ZERO;
      mem_we <= 1'b0;
      wb_rd  <= REG_ZERO;
      wb_we  <= 1'b0;
      haz_q  <= RUN;
    end else begin
      haz_q <= act;
      if (!freeze) begin
        mem_rd <= rd_IDOut;
        mem_we <= regWrite_IDOut;
        wb_rd  <= mem_rd;
        wb_we  <= mem_we;
      end
    end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk)
    if (rst) begin
      stallCount  <= '0;
      flushCount  <= '0;
      freezeCount <= '0;
    end else begin
      if (act == LOAD_STALL) stallCount <= stallCount + 32'd1;
      if (act == FLUSH) flushCount <= flushCount + 32'd1;
      if (act == FREEZE) freezeCount <= freezeCount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed scenarios plus random stimulus against a history-log reference model
module tb_hazard_forward_unit;
  logic       clk, rst;
  logic [4:0] rs1_ID, rs2_ID, rd_IDOut, rs1_IDOut, rs2_IDOut;
  logic       usesRs1_ID, usesRs2_ID, regWrite_IDOut, memRead_IDOut, branchTaken_EX, memBusy_MEM;
  logic       stallPC, stallIFID, bubbleIDEX, flushIFID, freeze;
  logic [1:0] forwardA, forwardB, hazState;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCount, flushCount, freezeCount;
`endif
  int n_checks = 0;
  int n_fail = 0;
  hazard_forward_unit dut (
    .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .usesRs1_ID(usesRs1_ID),
    .usesRs2_ID(usesRs2_ID), .rd_IDOut(rd_IDOut), .rs1_IDOut(rs1_IDOut), .rs2_IDOut(rs2_IDOut),
    .regWrite_IDOut(regWrite_IDOut), .memRead_IDOut(memRead_IDOut), .branchTaken_EX(branchTaken_EX),
    .memBusy_MEM(memBusy_MEM), .stallPC(stallPC), .stallIFID(stallIFID), .bubbleIDEX(bubbleIDEX),
    .flushIFID(flushIFID), .freeze(freeze), .forwardA(forwardA), .forwardB(forwardB), .hazState(hazState)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCount(stallCount), .flushCount(flushCount), .freezeCount(freezeCount)
`endif
  );
  wire [4:0] ctl = {stallPC, stallIFID, bubbleIDEX, flushIFID, freeze};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Reference model: a log of every instruction that left EX; MEM is the newest entry, WB the one before.
  logic [5:0]  hist [0:255];
  logic [7:0]  n_ret;
  logic [1:0]  m_haz;
  logic [31:0] m_stall, m_flush, m_freeze;
  function automatic logic [1:0] exp_act();
    logic lu;
    lu = memRead_IDOut && rd_IDOut != 0 &&
         ((usesRs1_ID && rs1_ID == rd_IDOut) || (usesRs2_ID && rs2_ID == rd_IDOut));
    if (memBusy_MEM) return 2'd3;
    if (branchTaken_EX) return 2'd2;
    if (lu) return 2'd1;
    return 2'd0;
  endfunction
  function automatic logic [4:0] exp_ctl(input logic [1:0] a);
    case (a)
      2'd3: return 5'b11001;
      2'd2: return 5'b00110;
      2'd1: return 5'b11100;
      default: return 5'b00000;
    endcase
  endfunction
  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    logic [5:0] m, w;
    m = hist[n_ret - 8'd1];
    w = hist[n_ret - 8'd2];
    if (m[5] && m[4:0] != 0 && m[4:0] == rs) return 2'b10;
    if (w[5] && w[4:0] != 0 && w[4:0] == rs) return 2'b01;
    return 2'b00;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      n_ret <= 8'd2;
      hist[0] <= 6'd0;
      hist[1] <= 6'd0;
      m_haz <= 2'd0;
      m_stall <= 0;
      m_flush <= 0;
      m_freeze <= 0;
    end else begin
      m_haz <= exp_act();
      if (exp_act() != 2'd3) begin
        hist[n_ret] <= {regWrite_IDOut, rd_IDOut};
        n_ret <= n_ret + 8'd1;
      end
      if (exp_act() == 2'd1) m_stall <= m_stall + 1;
      if (exp_act() == 2'd2) m_flush <= m_flush + 1;
      if (exp_act() == 2'd3) m_freeze <= m_freeze + 1;
    end
  end
  task automatic idle();
    rs1_ID = 0; rs2_ID = 0; usesRs1_ID = 0; usesRs2_ID = 0;
    rd_IDOut = 0; rs1_IDOut = 0; rs2_IDOut = 0; regWrite_IDOut = 0;
    memRead_IDOut = 0; branchTaken_EX = 0; memBusy_MEM = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; idle(); tick(); tick(); rst = 0;
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({ctl, forwardA, forwardB, hazState} !== 11'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", {ctl, forwardA, forwardB, hazState}, 11'd0);
    end
  endtask
  task automatic test_forward();
    do_reset();
    rd_IDOut = 5; regWrite_IDOut = 1; tick();
    idle(); rs1_IDOut = 5; rs2_IDOut = 5;
    @(negedge clk);
    n_checks++;
    if ({forwardA, forwardB} !== 4'b1010) begin
      n_fail++; $display("FAIL fwd_mem: got %b expected %b", {forwardA, forwardB}, 4'b1010);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({forwardA, forwardB} !== 4'b0101) begin
      n_fail++; $display("FAIL fwd_wb: got %b expected %b", {forwardA, forwardB}, 4'b0101);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({forwardA, forwardB} !== 4'b0000) begin
      n_fail++; $display("FAIL fwd_none: got %b expected %b", {forwardA, forwardB}, 4'b0000);
    end
    idle(); rd_IDOut = 3; regWrite_IDOut = 1; tick(); tick();
    idle(); rs1_IDOut = 3;
    @(negedge clk);
    n_checks++;
    if (forwardA !== 2'b10) begin
      n_fail++; $display("FAIL fwd_mem_priority: got %b expected %b", forwardA, 2'b10);
    end
    tick();
  endtask
  task automatic test_load_use();
    do_reset();
    rd_IDOut = 7; memRead_IDOut = 1; regWrite_IDOut = 1; rs2_ID = 7; usesRs2_ID = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 5'b11100) begin
      n_fail++; $display("FAIL load_use_stall: got %b expected %b", ctl, 5'b11100);
    end
    tick();
    rd_IDOut = 0; memRead_IDOut = 0; regWrite_IDOut = 0;
    @(negedge clk);
    n_checks++;
    if ({ctl, hazState} !== {5'b00000, 2'b01}) begin
      n_fail++; $display("FAIL load_use_one_cycle: got %b expected %b", {ctl, hazState}, 7'b0000001);
    end
    tick();
    idle(); rs2_IDOut = 7;
    @(negedge clk);
    n_checks++;
    if (forwardB !== 2'b01) begin
      n_fail++; $display("FAIL load_fwd_wb: got %b expected %b", forwardB, 2'b01);
    end
    tick();
  endtask
  task automatic test_load_flush();
    do_reset();
    rd_IDOut = 7; memRead_IDOut = 1; regWrite_IDOut = 1; rs1_ID = 7; usesRs1_ID = 1; branchTaken_EX = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 5'b00110) begin
      n_fail++; $display("FAIL flush_over_load: got %b expected %b", ctl, 5'b00110);
    end
    tick(); idle();
    @(negedge clk);
    n_checks++;
    if (hazState !== 2'b10) begin
      n_fail++; $display("FAIL flush_state: got %b expected %b", hazState, 2'b10);
    end
  endtask
  task automatic test_freeze();
    do_reset();
    rd_IDOut = 9; regWrite_IDOut = 1; tick();
    rd_IDOut = 4; memBusy_MEM = 1; branchTaken_EX = 1; rs1_IDOut = 9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ctl, forwardA} !== {5'b11001, 2'b10}) begin
        n_fail++; $display("FAIL freeze_cycle%0d: got %b expected %b", i, {ctl, forwardA}, 7'b1100110);
      end
      tick();
    end
    memBusy_MEM = 0;
    @(negedge clk);
    n_checks++;
    if ({ctl, forwardA, hazState} !== {5'b00110, 2'b10, 2'b11}) begin
      n_fail++; $display("FAIL freeze_release: got %b expected %b", {ctl, forwardA, hazState}, 9'b001101011);
    end
    tick(); idle(); rs1_IDOut = 9;
    @(negedge clk);
    n_checks++;
    if (forwardA !== 2'b01) begin
      n_fail++; $display("FAIL freeze_shadow_advance: got %b expected %b", forwardA, 2'b01);
    end
    memBusy_MEM = 1; rd_IDOut = 9; regWrite_IDOut = 1; tick();
    rst = 1; tick(); rst = 0; idle(); rs1_IDOut = 9;
    @(negedge clk);
    n_checks++;
    if ({forwardA, hazState, ctl} !== 9'd0) begin
      n_fail++; $display("FAIL reset_mid_freeze: got %b expected %b", {forwardA, hazState, ctl}, 9'd0);
    end
  endtask
  task automatic test_x0();
    do_reset();
    regWrite_IDOut = 1; rd_IDOut = 0; tick();
    idle(); memRead_IDOut = 1; rs1_ID = 0; usesRs1_ID = 1; rs2_ID = 0; usesRs2_ID = 1;
    @(negedge clk);
    n_checks++;
    if ({forwardA, forwardB, ctl} !== 9'd0) begin
      n_fail++; $display("FAIL x0_ignored: got %b expected %b", {forwardA, forwardB, ctl}, 9'd0);
    end
    tick(); idle();
  endtask
  task automatic test_random();
    logic [1:0] a;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      rs1_ID = 5'($urandom_range(0, 3)); rs2_ID = 5'($urandom_range(0, 3));
      usesRs1_ID = 1'($urandom); usesRs2_ID = 1'($urandom);
      rd_IDOut = 5'($urandom_range(0, 3)); rs1_IDOut = 5'($urandom_range(0, 3)); rs2_IDOut = 5'($urandom_range(0, 3));
      regWrite_IDOut = 1'($urandom); memRead_IDOut = ($urandom_range(0, 2) == 0);
      branchTaken_EX = ($urandom_range(0, 5) == 0); memBusy_MEM = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      a = exp_act();
      n_checks++;
      if (ctl !== exp_ctl(a)) begin
        n_fail++; $display("FAIL rand_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl(a));
      end
      n_checks++;
      if ({forwardA, forwardB} !== {exp_fwd(rs1_IDOut), exp_fwd(rs2_IDOut)}) begin
        n_fail++; $display("FAIL rand_fwd[%0d]: got %b expected %b", i, {forwardA, forwardB}, {exp_fwd(rs1_IDOut), exp_fwd(rs2_IDOut)});
      end
      n_checks++;
      if (hazState !== m_haz) begin
        n_fail++; $display("FAIL rand_state[%0d]: got %b expected %b", i, hazState, m_haz);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if ({stallCount, flushCount, freezeCount} !== {m_stall, m_flush, m_freeze}) begin
        n_fail++; $display("FAIL rand_counts[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                           stallCount, flushCount, freezeCount, m_stall, m_flush, m_freeze);
      end
`endif
      tick();
    end
    rst = 0; idle();
  endtask
`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rd_IDOut = 6; memRead_IDOut = 1; regWrite_IDOut = 1; rs1_ID = 6; usesRs1_ID = 1; tick();
      idle(); tick();
    end
    branchTaken_EX = 1; tick(); idle();
    memBusy_MEM = 1; repeat (4) tick(); idle();
    @(negedge clk);
    n_checks++;
    if ({stallCount, flushCount, freezeCount} !== {32'd2, 32'd1, 32'd4}) begin
      n_fail++; $display("FAIL perf_counts: got %0d/%0d/%0d expected 2/1/4", stallCount, flushCount, freezeCount);
    end
    rst = 1; tick(); rst = 0;
    @(negedge clk);
    n_checks++;
    if ({stallCount, flushCount, freezeCount} !== 96'd0) begin
      n_fail++; $display("FAIL perf_reset: got %0d/%0d/%0d expected 0/0/0", stallCount, flushCount, freezeCount);
    end
    tick();
  endtask
`endif
  initial begin
    rst = 1; idle(); tick();
    test_reset();
    test_forward();
    test_load_use();
    test_load_flush();
    test_freeze();
    test_x0();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
